// File: rtl/lamp_monitor.sv
// Traffic-lamp sequence monitor: tracks RED->GREEN->YELLOW->RED, flags faults, counts cycles.
// Optional dwell-timeout check enabled by defining LAMP_MONITOR_DWELL_CHECK_EN.
module lamp_monitor #(
  parameter int CNT_W     = 16,
  parameter int MAX_DWELL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       light,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic             locked,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             err_sticky,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [2:0] RED    = 3'b001;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b100;

  localparam logic [1:0] F_INVALID = 2'd1;
  localparam logic [1:0] F_ILLEGAL = 2'd2;
  localparam logic [1:0] F_DWELL   = 2'd3;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    S_RED    = 2'd1,
    S_GREEN  = 2'd2,
    S_YELLOW = 2'd3
  } state_t;

  if (MAX_DWELL < 1 || MAX_DWELL > 255) begin : g_bad_dwell
    $error("lamp_monitor: MAX_DWELL must be in 1..255");
  end

  state_t     state, state_n;
  logic       fault;
  logic [1:0] fcode;
  logic       bump;
  logic       valid;
  logic [1:0] dec;
  logic [2:0] own_code, nxt_code;
  state_t     nxt_state;

`ifdef LAMP_MONITOR_DWELL_CHECK_EN
  logic [7:0] dwell, dwell_n;
`endif

  always_comb begin
    valid = (light == RED) || (light == GREEN) || (light == YELLOW);
    unique case (light)
      RED:     dec = 2'd0;
      GREEN:   dec = 2'd1;
      YELLOW:  dec = 2'd2;
      default: dec = 2'd3;
    endcase
  end

  always_comb begin
    own_code  = RED;
    nxt_code  = GREEN;
    nxt_state = S_GREEN;
    unique case (state)
      S_GREEN: begin
        own_code  = GREEN;
        nxt_code  = YELLOW;
        nxt_state = S_YELLOW;
      end
      S_YELLOW: begin
        own_code  = YELLOW;
        nxt_code  = RED;
        nxt_state = S_RED;
      end
      default: begin
        own_code  = RED;
        nxt_code  = GREEN;
        nxt_state = S_GREEN;
      end
    endcase
  end

  // Fault checks are ordered so invalid code beats illegal transition beats timeout.
  always_comb begin
    state_n = state;
    fault   = 1'b0;
    fcode   = 2'd0;
    bump    = 1'b0;
`ifdef LAMP_MONITOR_DWELL_CHECK_EN
    dwell_n = dwell;
`endif
    if (state == HUNT) begin
      if (light == RED) begin
        state_n = S_RED;
`ifdef LAMP_MONITOR_DWELL_CHECK_EN
        dwell_n = 8'd1;
`endif
      end
    end else begin
      if (!valid) begin
        fault = 1'b1;
        fcode = F_INVALID;
      end else if (light == own_code) begin
`ifdef LAMP_MONITOR_DWELL_CHECK_EN
        if (dwell == 8'(MAX_DWELL)) begin
          fault = 1'b1;
          fcode = F_DWELL;
        end else begin
          dwell_n = dwell + 8'd1;
        end
`endif
      end else if (light == nxt_code) begin
        state_n = nxt_state;
        bump    = (state == S_YELLOW);
`ifdef LAMP_MONITOR_DWELL_CHECK_EN
        dwell_n = 8'd1;
`endif
      end else begin
        fault = 1'b1;
        fcode = F_ILLEGAL;
      end
      if (fault) begin
        state_n = HUNT;
`ifdef LAMP_MONITOR_DWELL_CHECK_EN
        dwell_n = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      phase      <= 2'd3;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
      err_sticky <= 1'b0;
      cycle_cnt  <= '0;
`ifdef LAMP_MONITOR_DWELL_CHECK_EN
      dwell      <= '0;
`endif
    end else begin
      state  <= state_n;
      phase  <= dec;
      locked <= (state_n != HUNT);
      err    <= fault;
      if (fault) begin
        err_code <= fcode;
      end
      if (fault) begin
        err_sticky <= 1'b1;
      end else if (clr_err) begin
        err_sticky <= 1'b0;
      end
      if (bump && (cycle_cnt != '1)) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
`ifdef LAMP_MONITOR_DWELL_CHECK_EN
      dwell <= dwell_n;
`endif
    end
  end

endmodule

// File: doc/lamp_monitor.md
LAMP_MONITOR -- requirements
Module: lamp_monitor

Interface
REQ-001 Parameter: CNT_W, default 16, width of the completed-cycle counter.
REQ-002 Parameter: MAX_DWELL, default 8, maximum consecutive samples of one colour; legal range 1..255.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: light  input  3  observed lamp code: RED=3'b001, GREEN=3'b010, YELLOW=3'b100.
REQ-006 Port: clr_err  input  1  clears err_sticky.
REQ-007 Port: phase  output  2  registered decode: 0 RED, 1 GREEN, 2 YELLOW, 3 invalid.
REQ-008 Port: locked  output  1  high while tracking a legal sequence.
REQ-009 Port: err  output  1  one-cycle pulse per detected fault.
REQ-010 Port: err_code  output  2  cause of the most recent fault: 1 invalid code, 2 illegal transition, 3 dwell timeout; 0 none since reset.
REQ-011 Port: err_sticky  output  1  set by any fault; held until cleared.
REQ-012 Port: cycle_cnt  output  CNT_W  count of completed RED->GREEN->YELLOW->RED cycles.

Function
REQ-013 The FSM shall have states HUNT, S_RED, S_GREEN and S_YELLOW.
REQ-014 All outputs shall be registered, with 1-cycle latency from the light sample to the outputs.
REQ-015 phase shall reflect the decode of light from the previous edge in every state, including HUNT.
REQ-016 HUNT: light==RED -> S_RED with dwell=1; all other codes stay in HUNT with no fault.
REQ-017 S_X, same colour: dwell increments; if dwell already equals MAX_DWELL -> fault 3 and next state HUNT.
REQ-018 S_X, next colour (RED->GREEN->YELLOW->RED): advance to that colour's state with dwell=1.
REQ-019 S_YELLOW->S_RED advance shall increment cycle_cnt, saturating at all-ones with no wrap.
REQ-020 S_X, light not one-hot among the three codes (including 3'b000): fault 1, next state HUNT.
REQ-021 S_X, legal code that is neither the same colour nor the next colour: fault 2, next state HUNT.
REQ-022 On a fault, the next state shall be HUNT regardless of light; a RED on that same sample shall not relock.
REQ-023 Fault priority when several apply: 1 > 2 > 3; only one err pulse per cycle.
REQ-024 locked shall be 1 in S_RED, S_GREEN and S_YELLOW, and 0 in HUNT.
REQ-025 err_code shall update only on a fault and hold otherwise.
REQ-026 clr_err shall clear err_sticky on the next edge; a fault in the same cycle wins and err_sticky stays 1.

Reset
REQ-027 When rst is high at an edge: state=HUNT, dwell=0, phase=3, locked=0, err=0, err_code=0, err_sticky=0, cycle_cnt=0.
REQ-028 rst shall take priority over all inputs; reset mid-sequence shall discard progress, and the first post-reset RED shall relock.

Configuration
REQ-029 Macro LAMP_MONITOR_DWELL_CHECK_EN defined: dwell counter and fault 3 shall be implemented per REQ-017.
REQ-030 Macro undefined: no dwell counter; the same colour shall stay in state indefinitely; err_code shall never be 3.

Verification
REQ-031 Reset then light RED,GREEN,YELLOW,RED repeated 3 times -> locked=1 from the 2nd edge, cycle_cnt=3, err never asserted.
REQ-032 Locked in S_GREEN, light=3'b011 -> err pulse, err_code=1, err_sticky=1, locked=0 next cycle; phase=3.
REQ-033 Locked in S_RED, light=YELLOW -> err_code=2, HUNT; subsequent RED relocks one cycle later.
REQ-034 With macro defined and MAX_DWELL=4, RED held 5 samples -> fault 3 on the 5th sample; RED held 4 samples then GREEN -> no fault.
REQ-035 err_sticky=1, clr_err=1 in the same cycle as a fault 2 -> err_sticky stays 1; clr_err alone next cycle -> 0.
REQ-036 With CNT_W=2, 5 full cycles -> cycle_cnt saturates at 3; rst mid-S_GREEN -> all outputs at reset values next cycle.
